uart_bus_arbiter: RTL and testbench

//  Shares the 8-bit UART/misc register bus (addr/wdata/rd/wr/rdata) between NREQ

---
 rtl/uart_bus_arbiter_pkg.sv | 26 ++
 rtl/uart_bus_arbiter_if.sv | 29 ++
 rtl/uart_bus_arbiter_rr_arbiter.sv | 55 +++++
 rtl/uart_bus_arbiter.sv | 110 +++++++++++
 tb/tb_uart_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bus_arbiter_pkg.sv
// Shared definitions for the UART/misc register bus arbiter: FSM state codes,
// register map constants and small helpers.
package uart_bus_arbiter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_ACK     = 2'd3;

   // Register map: UART n occupies 16*n + {DATA, STATUS, DIV_LO, DIV_HI}
   localparam int         UART_DATA   = 0;
   localparam int         UART_STATUS = 1;
   localparam int         UART_DIV_LO = 2;
   localparam int         UART_DIV_HI = 3;
   localparam logic [7:0] MISC_OUT    = 8'd128;
   localparam logic [7:0] MISC_IN     = 8'd129;

   function automatic logic [7:0] uart_reg_addr(input int n, input int off);
      return 8'(16 * n + off);
   endfunction

   function automatic int ptr_width(input int nreq);
      return (nreq > 2) ? 2 : 1;
   endfunction

endpackage

// File: rtl/uart_bus_arbiter_if.sv
// Requester-side and register-bus-side signals of the arbiter, bundled.
// The arbiter uses the slave view; requesters plus register file use master.
interface uart_bus_arbiter_if #(
   parameter int NREQ = 2,
   parameter int AW   = 8,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]    req_ack;
   logic [DW-1:0]      resp_rdata;
   logic [AW-1:0]      bus_addr;
   logic [DW-1:0]      bus_wdata;
   logic               bus_rd;
   logic               bus_wr;
   logic [DW-1:0]      bus_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, bus_rdata,
      input  req_ack, resp_rdata, bus_addr, bus_wdata, bus_rd, bus_wr
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, bus_rdata,
      output req_ack, resp_rdata, bus_addr, bus_wdata, bus_rd, bus_wr
   );
endinterface

// File: rtl/uart_bus_arbiter_rr_arbiter.sv
// Round-robin winner selection: lowest requester at or after the pointer wins,
// wrapping to the lowest overall. Pointer advances past the winner on update.
module rr_arbiter
   import uart_bus_arbiter_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            update,
   output logic [NREQ-1:0] gnt_onehot,
   output logic            any_req
);
   localparam int PW = ptr_width(NREQ);

   logic [PW-1:0]   ptr_reg;
   logic [PW-1:0]   ptr_next;
   logic [PW-1:0]   gnt_idx;
   logic [NREQ-1:0] at_or_after;
   logic [NREQ-1:0] req_hi;
   logic [NREQ-1:0] pick_hi;
   logic [NREQ-1:0] pick_all;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign at_or_after[gi] = (PW'(gi) >= ptr_reg);
      end
   endgenerate

   // x & -x isolates the lowest set bit; prefer the masked set when non-empty
   assign req_hi     = req & at_or_after;
   assign pick_hi    = req_hi & (~req_hi + NREQ'(1));
   assign pick_all   = req & (~req + NREQ'(1));
   assign gnt_onehot = (|req_hi) ? pick_hi : pick_all;
   assign any_req    = |req;

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_onehot[k]) gnt_idx = PW'(k);
      end
   end

   assign ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (update) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the 8-bit UART/misc register bus between NREQ requesters, one access
// in flight: IDLE -> ISSUE (strobe) -> CAPTURE (read data) -> ACK.
module uart_bus_arbiter
   import uart_bus_arbiter_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int AW   = 8,
   parameter int DW   = 8
) (
   input  logic               clk,
   input  logic               reset,
   uart_bus_arbiter_if.slave  bus
);
   logic [1:0]      state_reg;
   logic [1:0]      state_next;
   logic [NREQ-1:0] grant_reg;
   logic            we_reg;
   logic [AW-1:0]   bus_addr_reg;
   logic [DW-1:0]   bus_wdata_reg;
   logic            bus_rd_reg;
   logic            bus_wr_reg;
   logic [NREQ-1:0] req_ack_reg;
   logic [DW-1:0]   resp_rdata_reg;

   logic [NREQ-1:0] gnt_onehot;
   logic            any_req;
   logic            arb_update;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;

   // Requests only count in IDLE, so a stale req_valid during ACK is ignored
   assign arb_update = (state_reg == ST_IDLE) && any_req;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk        (clk),
      .reset      (reset),
      .req        (bus.req_valid),
      .update     (arb_update),
      .gnt_onehot (gnt_onehot),
      .any_req    (any_req)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_onehot[k]) begin
            sel_we    = bus.req_we[k];
            sel_addr  = bus.req_addr[AW*k +: AW];
            sel_wdata = bus.req_wdata[DW*k +: DW];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (any_req) state_next = ST_ISSUE;
         ST_ISSUE:   state_next = ST_CAPTURE;
         ST_CAPTURE: state_next = ST_ACK;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         grant_reg      <= '0;
         we_reg         <= 1'b0;
         bus_addr_reg   <= '0;
         bus_wdata_reg  <= '0;
         bus_rd_reg     <= 1'b0;
         bus_wr_reg     <= 1'b0;
         req_ack_reg    <= '0;
         resp_rdata_reg <= '0;
      end else begin
         state_reg   <= state_next;
         bus_rd_reg  <= 1'b0;
         bus_wr_reg  <= 1'b0;
         req_ack_reg <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (any_req) begin
                  grant_reg     <= gnt_onehot;
                  we_reg        <= sel_we;
                  bus_addr_reg  <= sel_addr;
                  bus_wdata_reg <= sel_wdata;
                  bus_wr_reg    <= sel_we;
                  bus_rd_reg    <= ~sel_we;
               end
            end
            ST_CAPTURE: begin
               if (!we_reg) resp_rdata_reg <= bus.bus_rdata;
               req_ack_reg <= grant_reg;
            end
            default: ;
         endcase
      end
   end

   assign bus.bus_addr   = bus_addr_reg;
   assign bus.bus_wdata  = bus_wdata_reg;
   assign bus.bus_rd     = bus_rd_reg;
   assign bus.bus_wr     = bus_wr_reg;
   assign bus.req_ack    = req_ack_reg;
   assign bus.resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Randomised bench for uart_bus_arbiter: a transaction-level model predicts
// bus strobes and acks into queues; a negedge monitor pops and compares.
module tb_uart_bus_arbiter;
   import uart_bus_arbiter_pkg::*;

   localparam int NREQ = 2;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_bus_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   uart_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int         gap;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } acc_t;

   typedef struct {
      int         cyc;
      bit         we;
      int         idx;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } exp_t;

   acc_t rq [NREQ][$];
   exp_t exp_bus[$];
   exp_t exp_ack[$];

   int cyc       = 0;
   int n_vec     = 0;
   int n_err     = 0;
   int zero_cyc  = -1;
   int final_cyc = -1;

   // ---------------- register file environment ----------------
   logic [7:0] mem [256];
   bit         written [256];

   always @(posedge clk) begin
      if (bus.bus_wr === 1'b1) begin
         mem[bus.bus_addr]     <= bus.bus_wdata;
         written[bus.bus_addr] <= 1'b1;
      end
      if (bus.bus_rd === 1'b1)
         bus.bus_rdata <= written[bus.bus_addr] ? mem[bus.bus_addr] : (bus.bus_addr ^ 8'h5A);
      else
         bus.bus_rdata <= 8'($urandom);
   end

   // ---------------- transaction-level reference model ----------------
   // One decision every 4 cycles at most; rotating priority starting at ptr.
   int         m_ptr  = 0;
   int         m_busy = 0;
   logic [7:0] shadow [256];
   bit         sh_written [256];

   always @(posedge clk) begin
      int   win;
      int   j;
      exp_t e;
      if (reset) begin
         m_ptr  = 0;
         m_busy = 0;
         exp_bus.delete();
         exp_ack.delete();
      end else if (m_busy > 0) begin
         m_busy--;
      end else begin
         win = -1;
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (win < 0 && bus.req_valid[j]) win = j;
         end
         if (win >= 0) begin
            e.we    = bus.req_we[win];
            e.idx   = win;
            e.addr  = bus.req_addr[AW*win +: AW];
            e.wdata = bus.req_wdata[DW*win +: DW];
            if (e.we) begin
               shadow[e.addr]     = e.wdata;
               sh_written[e.addr] = 1'b1;
               e.rdata            = 8'h00;
            end else begin
               e.rdata = sh_written[e.addr] ? shadow[e.addr] : (e.addr ^ 8'h5A);
            end
            e.cyc = cyc + 1;
            exp_bus.push_back(e);
            e.cyc = cyc + 3;
            exp_ack.push_back(e);
            m_ptr  = (win + 1) % NREQ;
            m_busy = 3;
         end
      end
      cyc++;
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   int         held [NREQ];
   logic [7:0] exp_resp = 8'h00;

   always @(negedge clk) begin
      exp_t e;
      if (cyc == zero_cyc) begin
         chk("rst_bus_rd",     32'(bus.bus_rd),     32'd0);
         chk("rst_bus_wr",     32'(bus.bus_wr),     32'd0);
         chk("rst_bus_addr",   32'(bus.bus_addr),   32'd0);
         chk("rst_bus_wdata",  32'(bus.bus_wdata),  32'd0);
         chk("rst_req_ack",    32'(bus.req_ack),    32'd0);
         chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
      end
      if (cyc == final_cyc) begin
         chk("pending_strobes", 32'(exp_bus.size()), 32'd0);
         chk("pending_acks",    32'(exp_ack.size()), 32'd0);
      end
      if (reset) begin
         exp_resp = 8'h00;
         for (int i = 0; i < NREQ; i++) held[i] = 0;
      end else begin
         chk("rd_wr_overlap", 32'(bus.bus_rd & bus.bus_wr), 32'd0);
         if (bus.bus_rd || bus.bus_wr) begin
            if (exp_bus.size() == 0) begin
               chk("strobe_unexpected_queue", 32'(exp_bus.size()), 32'd1);
            end else begin
               e = exp_bus.pop_front();
               chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
               chk("strobe_kind", 32'({bus.bus_wr, bus.bus_rd}), e.we ? 32'd2 : 32'd1);
               chk("bus_addr", 32'(bus.bus_addr), 32'(e.addr));
               if (e.we) chk("bus_wdata", 32'(bus.bus_wdata), 32'(e.wdata));
            end
         end else if (exp_bus.size() > 0 && exp_bus[0].cyc < cyc) begin
            e = exp_bus.pop_front();
            chk("strobe_missing_cycle", 32'(cyc), 32'(e.cyc));
         end
         if (bus.req_ack != '0) begin
            if (exp_ack.size() == 0) begin
               chk("ack_unexpected", 32'(bus.req_ack), 32'd0);
            end else begin
               e = exp_ack.pop_front();
               chk("ack_cycle", 32'(cyc), 32'(e.cyc));
               chk("ack_vector", 32'(bus.req_ack), 32'd1 << e.idx);
               if (!e.we) begin
                  chk("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
                  exp_resp = e.rdata;
               end else begin
                  chk("resp_rdata_hold", 32'(bus.resp_rdata), 32'(exp_resp));
               end
               $display("txn cyc=%0d req%0d %s addr=%02h data=%02h", cyc, e.idx,
                        e.we ? "WR" : "RD", e.addr, e.we ? e.wdata : e.rdata);
            end
         end else if (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
            e = exp_ack.pop_front();
            chk("ack_missing_cycle", 32'(cyc), 32'(e.cyc));
         end
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && !bus.req_ack[i]) held[i]++;
            else held[i] = 0;
            if (held[i] == 64) chk("req_held_cycles", 32'(held[i]), 32'd63);
         end
      end
   end

   // ---------------- requester drivers ----------------
   logic [NREQ-1:0]    v_valid = '0;
   logic [NREQ-1:0]    v_we    = '0;
   logic [NREQ*AW-1:0] v_addr  = '0;
   logic [NREQ*DW-1:0] v_wdata = '0;
   bit                 active  [NREQ];
   int                 gap_cnt [NREQ];

   function automatic acc_t mk(input int gap, input bit we, input logic [7:0] addr,
                               input logic [7:0] wdata);
      acc_t a;
      a.gap = gap; a.we = we; a.addr = addr; a.wdata = wdata;
      return a;
   endfunction

   function automatic logic [7:0] rand_addr();
      int p;
      p = int'($urandom_range(0, 9));
      if (p < 8) return uart_reg_addr(p / 4, p % 4);
      return (p == 8) ? MISC_OUT : MISC_IN;
   endfunction

   function automatic bit drivers_busy();
      for (int i = 0; i < NREQ; i++)
         if (active[i] || rq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Called at posedge+1: retire on ack, then present next access after its gap
   task automatic step();
      acc_t a;
      for (int i = 0; i < NREQ; i++) begin
         if (active[i] && bus.req_ack[i] === 1'b1) begin
            active[i]  = 1'b0;
            v_valid[i] = 1'b0;
         end
         if (!active[i] && rq[i].size() > 0) begin
            if (gap_cnt[i] < rq[i][0].gap) begin
               gap_cnt[i]++;
            end else begin
               a = rq[i].pop_front();
               active[i]  = 1'b1;
               gap_cnt[i] = 0;
               v_valid[i] = 1'b1;
               v_we[i]    = a.we;
               v_addr[AW*i +: AW]  = a.addr;
               v_wdata[DW*i +: DW] = a.wdata;
            end
         end
      end
      bus.req_valid = v_valid;
      bus.req_we    = v_we;
      bus.req_addr  = v_addr;
      bus.req_wdata = v_wdata;
   endtask

   task automatic run(input int max_cyc);
      int n;
      n = 0;
      while (drivers_busy() && n < max_cyc) begin
         @(posedge clk); #1;
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      bus.req_valid = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         active[i]  = 1'b0;
         gap_cnt[i] = 0;
      end

      // both requesters held from reset: grants alternate 0,1,0,1
      for (int k = 0; k < 2; k++) begin
         rq[0].push_back(mk(0, 1'b1, uart_reg_addr(1, UART_DIV_LO), 8'(8'h40 + k)));
         rq[1].push_back(mk(0, 1'b1, uart_reg_addr(1, UART_DIV_HI), 8'(8'h50 + k)));
      end
      zero_cyc = 3;
      repeat (4) begin
         @(posedge clk); #1;
         step();
      end
      reset = 1'b0;
      run(200);

      // single write, then write-then-read of addr 17, then RX-data pop
      rq[0].push_back(mk(0, 1'b1, uart_reg_addr(0, UART_DIV_LO), 8'h1B));
      run(100);
      rq[0].push_back(mk(0, 1'b1, uart_reg_addr(1, UART_STATUS), 8'h2A));
      run(100);
      rq[1].push_back(mk(0, 1'b0, uart_reg_addr(1, UART_STATUS), 8'h00));
      run(100);
      rq[1].push_back(mk(0, 1'b0, uart_reg_addr(0, UART_DATA), 8'h00));
      run(100);

      // back-to-back writes from req0, req1 arriving mid-access
      for (int k = 0; k < 4; k++)
         rq[0].push_back(mk(0, 1'b1, MISC_OUT, 8'(8'hA0 + k)));
      rq[1].push_back(mk(5, 1'b0, MISC_IN, 8'h00));
      run(200);

      // randomised mixed traffic
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < NREQ; i++)
            rq[i].push_back(mk(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                               rand_addr(), 8'($urandom)));
      end
      run(2000);

      // reset during CAPTURE of a req0 read: no ack; pointer returns to 0
      rq[0].push_back(mk(0, 1'b0, uart_reg_addr(0, UART_DATA), 8'h00));
      n = 0;
      do begin
         @(posedge clk); #1;
         step();
         n++;
      end while (bus.bus_rd !== 1'b1 && n < 50);
      @(posedge clk); #1;
      step();
      reset    = 1'b1;
      zero_cyc = cyc + 1;
      rq[1].push_back(mk(0, 1'b1, MISC_OUT, 8'h77));
      @(posedge clk); #1;
      step();
      reset = 1'b0;
      run(200);

      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < NREQ; i++)
            rq[i].push_back(mk(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                               rand_addr(), 8'($urandom)));
      end
      run(1000);

      repeat (2) @(posedge clk);
      #1;
      final_cyc = cyc + 1;
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
